// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched
//   Round-robin scheduler that shares one 16:1 mux datapath between 16
//   requesters. It drives the mux select, a one-hot grant and a valid flag.
//   A grant is kept while its request stays high, for at most HOLD_MAX
//   cycles, and then passes to the next requester in rotation.
//   All outputs are registered.
//
// Parameters
//   HOLD_MAX   maximum consecutive cycles one requester keeps the mux (>=1)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         scheduler enable; 0 forces IDLE on the next edge
//   req[15:0]  request vector, bit i = requester i (mux input Ii)
//   sel[3:0]   mux select {S3,S2,S1,S0}, index of the granted requester
//   gnt[15:0]  one-hot grant, 1<<sel while gnt_valid, otherwise zero
//   gnt_valid  sel/gnt are valid and the mux output is owned

module mux16_rr_sched #(
  parameter int HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] req,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        gnt_valid
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(HOLD_MAX);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state, next_state;
  logic [3:0]    ptr, next_ptr;
  logic [HW-1:0] hold_cnt, next_hold;
  logic [3:0]    next_sel;
  logic [15:0]   next_gnt;
  logic          next_valid;

  // Returns {found, index} of the first requester at or after 'start',
  // wrapping past 15 back to 0. Scanning from the farthest offset down
  // lets the nearest match overwrite the result last.
  function automatic logic [4:0] pick(input logic [15:0] r, input logic [3:0] start);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = start + 4'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [4:0] pick_ptr;
  logic [4:0] pick_nxt;

  // From IDLE the search starts at ptr; from GRANT it starts just past the
  // current owner, which also wraps back to the owner itself on expiry.
  assign pick_ptr = pick(req, ptr);
  assign pick_nxt = pick(req, sel + 4'd1);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      sel       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= next_state;
      ptr       <= next_ptr;
      hold_cnt  <= next_hold;
      sel       <= next_sel;
      gnt       <= next_gnt;
      gnt_valid <= next_valid;
    end
  end

  // Next-state decision.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (en && (|req)) next_state = GRANT;
      end
      GRANT: begin
        if (!en) next_state = IDLE;
        else if (!req[sel] && !pick_nxt[4]) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs. A release takes priority over
  // expiry, but both end in the same "grant pick_nxt" path, so no bubble.
  always_comb begin
    logic       take;
    logic [3:0] take_idx;
    logic       clear;

    take       = 1'b0;
    take_idx   = '0;
    clear      = 1'b0;
    next_ptr   = ptr;
    next_hold  = hold_cnt;
    next_sel   = sel;
    next_gnt   = gnt;
    next_valid = gnt_valid;

    case (state)
      IDLE: begin
        if (en && (|req)) begin
          take     = 1'b1;
          take_idx = pick_ptr[3:0];
        end else begin
          clear = 1'b1;
        end
      end
      GRANT: begin
        if (!en) begin
          clear = 1'b1;
        end else if (!req[sel]) begin
          if (pick_nxt[4]) begin
            take     = 1'b1;
            take_idx = pick_nxt[3:0];
          end else begin
            clear = 1'b1;
          end
        end else if (hold_cnt < HOLD_LIMIT) begin
          next_hold = hold_cnt + HW'(1);
        end else begin
          take     = 1'b1;
          take_idx = pick_nxt[3:0];
        end
      end
      default: clear = 1'b1;
    endcase

    // sel deliberately keeps its last value when the grant is dropped.
    if (clear) begin
      next_gnt   = '0;
      next_valid = 1'b0;
      next_hold  = '0;
    end

    if (take) begin
      next_sel   = take_idx;
      next_gnt   = 16'(1) << take_idx;
      next_valid = 1'b1;
      next_hold  = HW'(1);
      next_ptr   = take_idx + 4'd1;
    end
  end

endmodule
